// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin register-file write arbiter for two writeback requesters
// Optional macro SCRUB_EN adds a post-reset scrub of registers 1..31 before arbitration begins.
module wb_port_arbiter #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  SCRUB_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [4:0]       req0_rd,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_rd,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic             RegWrite,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  rd_write_data,
    output logic             busy
);

`ifdef SCRUB_EN
    typedef enum logic {ST_SCRUB, ST_ARB} state_t;

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
`endif

    // prio_q == 0 favours req0 on a tie, 1 favours req1
    logic            prio_q, prio_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            arb_en;
    logic            grant0, grant1;

`ifdef SCRUB_EN
    assign arb_en = rst_n && (state_q == ST_ARB);
    assign busy   = (state_q == ST_SCRUB);
`else
    assign arb_en = rst_n;
    assign busy   = 1'b0;
`endif

    assign grant0 = arb_en && req0_valid && (!req1_valid || !prio_q);
    assign grant1 = arb_en && req1_valid && (!req0_valid ||  prio_q);

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign RegWrite      = regwrite_q;
    assign rd            = rd_q;
    assign rd_write_data = data_q;

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        prio_d     = prio_q;
`ifdef SCRUB_EN
        state_d    = state_q;
        idx_d      = idx_q;
        case (state_q)
            ST_SCRUB: begin
                // idx wraps 31 -> 0, which marks the last scrub write as issued
                if (idx_q != 5'd0) begin
                    regwrite_d = 1'b1;
                    rd_d       = idx_q;
                    data_d     = SCRUB_VALUE;
                    idx_d      = idx_q + 5'd1;
                end else begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
`endif
        if (grant0) begin
            prio_d = 1'b1;
            if (req0_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rd_d       = req0_rd;
                data_d     = req0_data;
            end
        end else if (grant1) begin
            prio_d = 1'b0;
            if (req1_rd != 5'd0) begin
                regwrite_d = 1'b1;
                rd_d       = req1_rd;
                data_d     = req1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= '0;
        end else begin
            prio_q     <= prio_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

`ifdef SCRUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCRUB;
            idx_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
`endif

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of the register file write port.
REQ-002 Parameter SCRUB_VALUE, default 0: value written to every register during scrub.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port req0_valid  input  1: requester 0 (ALU writeback) has a write pending.
REQ-006 Port req0_rd  input  5: requester 0 destination register.
REQ-007 Port req0_data  input  XLEN: requester 0 write data.
REQ-008 Port req0_ready  output  1: requester 0 write accepted this cycle.
REQ-009 Ports req1_valid, req1_rd, req1_data, req1_ready: same as REQ-005..008, for requester 1 (load/multicycle writeback).
REQ-010 Port RegWrite  output  1: write enable to the register file.
REQ-011 Port rd  output  5: register file write address.
REQ-012 Port rd_write_data  output  XLEN: register file write data.
REQ-013 Port busy  output  1: high while scrub is in progress.

Function
REQ-014 The block SHALL have two states: SCRUB and ARB.
REQ-015 In SCRUB it SHALL write SCRUB_VALUE to registers 1..31 in ascending order, one per cycle (RegWrite=1, rd=index), with both readies low and busy=1.
REQ-016 After the index-31 write it SHALL enter ARB on the next cycle; there is no ARB-to-SCRUB transition except through reset.
REQ-017 In ARB, reqN_ready SHALL be a combinational function of the valids and the priority pointer; a transfer occurs when valid and ready are both high.
REQ-018 At most one ready SHALL be high per cycle; throughput is one accepted write per cycle.
REQ-019 With one valid, that requester SHALL be granted.
REQ-020 With both valid, the requester not granted most recently SHALL win (round-robin); the pointer updates only on a transfer.
REQ-021 An accepted write SHALL appear on RegWrite/rd/rd_write_data exactly one cycle after the transfer cycle (registered outputs, latency 1).
REQ-022 An accepted write with rd == 0 SHALL be consumed (ready high) but SHALL drive RegWrite=0 in the following cycle.
REQ-023 In any cycle without a transfer in the previous cycle, RegWrite SHALL be 0; rd and rd_write_data hold their last values.
REQ-024 The arbiter SHALL NOT depend on requesters holding valid stable; a dropped valid is simply not granted.

Reset
REQ-025 On rst_n low, immediately and independent of clk: RegWrite=0, rd=0, rd_write_data=0, scrub index=1, pointer favours req0, readies low.
REQ-026 The state after reset SHALL be SCRUB (busy=1) when SCRUB_EN is defined, otherwise ARB (busy=0).
REQ-027 Reset asserted mid-scrub or mid-transfer SHALL abandon the operation; an accepted write not yet driven SHALL be lost.
REQ-028 On rst_n release, the first write (scrub or arbitrated) SHALL occur no earlier than the first posedge clk after release.

Configuration
REQ-029 Macro SCRUB_EN: when defined, the SCRUB state, 5-bit index counter and busy logic SHALL be compiled in.
REQ-030 Without SCRUB_EN, the SCRUB state and counter SHALL be absent, busy SHALL be tied to 0, and ARB SHALL be entered directly from reset.

Verification
REQ-031 SCRUB_EN defined, release reset, no valids -> 31 consecutive cycles RegWrite=1, rd=1..31, data=0, busy=1; then busy=0 and RegWrite=0.
REQ-032 Both valid continuously (req0 rd=5 data=0xA, req1 rd=6 data=0xB) -> grants alternate req0, req1, req0, ...; outputs rd=5,6,5 one cycle later.
REQ-033 req1 valid alone with rd=0, data=0xDEAD -> req1_ready=1; next cycle RegWrite=0.
REQ-034 Assert rst_n low at scrub index 17 and release -> scrub restarts at rd=1 and completes all 31 writes.
REQ-035 SCRUB_EN undefined, req0 valid every cycle with rd=3..10 -> ready=1 every cycle, busy=0, eight consecutive RegWrite pulses with matching rd and data.
